// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive and transmit halves.
package spart_pkg;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic [DIV_W-1:0] DIV_MIN              = 16'd2;
    localparam logic [DIV_W-1:0] DEFAULT_DIVISOR_9600 = 16'd5208;

    localparam logic BAUD_LOC_LOW  = 1'b0;
    localparam logic BAUD_LOC_HIGH = 1'b1;

    // Divisors below DIV_MIN cannot produce a usable mid-bit sample point.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud divisor register plus reloadable bit-period down-counter.
// o_tick_c is combinational: high for the one cycle the running counter sits at 0.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEFAULT_DIVISOR = DEFAULT_DIVISOR_9600
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_write_en,
    input  logic              i_write_loc,
    input  logic [DATA_W-1:0] i_write_line,
    input  logic              i_run,
    input  logic              i_load,
    input  logic              i_load_half,
    output logic              o_tick_c
);

    logic [DIV_W-1:0] r_divisor;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] w_reload;

    // Reload value comes from the current divisor, so a same-cycle write affects only later reloads.
    assign w_div    = clamp_div(r_divisor);
    assign w_reload = i_load_half ? DIV_W'((w_div >> 1) - 16'd1) : DIV_W'(w_div - 16'd1);
    assign o_tick_c = i_run && (r_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_divisor <= DEFAULT_DIVISOR;
            r_cnt     <= '0;
        end else begin
            if (i_write_en) begin
                if (i_write_loc == BAUD_LOC_HIGH) r_divisor[15:8] <= i_write_line;
                else                              r_divisor[7:0]  <= i_write_line;
            end
            if (i_load)
                r_cnt <= w_reload;
            else if (i_run && (r_cnt != '0))
                r_cnt <= r_cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: rxd synchronizer, receive FSM and holding buffer with rda status.
// Define SPART_RX_FERR_EN to add the framing_err output and keep bad-stop bytes.
module spart_rx
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEFAULT_DIVISOR = DEFAULT_DIVISOR_9600,
    parameter int unsigned      SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              baud_write_en,
    input  logic              baud_write_location,
    input  logic [DATA_W-1:0] write_line,
    input  logic              receive_read_en,
    output logic [DATA_W-1:0] receive_read_line,
    output logic              rda,
`ifdef SPART_RX_FERR_EN
    output logic              framing_err,
`endif
    output logic              rx_busy
);

    rx_state_t         r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              w_rx_s;
    logic              w_tick;
    logic              w_load;
    logic              w_load_half;
    logic              w_run;

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_run       = (r_state != IDLE);
    assign w_load_half = (r_state == IDLE);
    // Counter loads on entry to START, DATA and STOP, and on every DATA tick.
    assign w_load      = ((r_state == IDLE) && !w_rx_s) ||
                         (w_tick && ((r_state == DATA) || ((r_state == START) && !w_rx_s)));

    spart_baud_gen #(
        .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
    ) u_baud (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_write_en  (baud_write_en),
        .i_write_loc (baud_write_location),
        .i_write_line(write_line),
        .i_run       (w_run),
        .i_load      (w_load),
        .i_load_half (w_load_half),
        .o_tick_c    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end

    // Read clear is written first so a same-cycle stop accept overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_bit_idx         <= '0;
            r_shift           <= '0;
            receive_read_line <= '0;
            rda               <= 1'b0;
            rx_busy           <= 1'b0;
`ifdef SPART_RX_FERR_EN
            framing_err       <= 1'b0;
`endif
        end else begin
            if (receive_read_en) begin
                rda         <= 1'b0;
`ifdef SPART_RX_FERR_EN
                framing_err <= 1'b0;
`endif
            end
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        rx_busy <= 1'b0;
                        if (w_rx_s) begin
                            receive_read_line <= r_shift;
                            rda               <= 1'b1;
                        end else begin
`ifdef SPART_RX_FERR_EN
                            receive_read_line <= r_shift;
                            framing_err       <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
